// File: rtl/camera_capture_if.sv
// Frame-buffer write port shared between the camera capture block and the
// dual-port frame buffer that the VGA reader scans out.
interface camera_capture_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] wraddress;
  logic [11:0]       wrdata;
  logic              wren;

  modport master (output wraddress, output wrdata, output wren);
  modport slave  (input  wraddress, input  wrdata, input  wren);
endinterface

// File: rtl/camera_capture.sv
// OV7670-style RGB444 capture: samples the asynchronous camera bus in the
// system clock domain, packs byte pairs into 12-bit pixels and writes them
// into a H_PIXELS x V_LINES frame buffer.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; wait for vsync high so a partial frame is never taken
// VBLANK | vertical blank; frame accepted on vsync fall if capture_en
// ACTIVE | capturing lines; vsync rise ends the frame
module camera_capture #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                cam_pclk,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_data,
  input  logic                capture_en,
  camera_capture_if.master    fb,
  output logic                frame_done,
  output logic [7:0]          frame_count,
  output logic                busy
);

  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIXELS);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;

  state_t            state;
  logic              pclk_s1, pclk_s2, pclk_s3;
  logic              vsync_s1, vsync_s2, vsync_s3;
  logic              href_s1, href_s2, href_s3;
  logic [7:0]        data_s1, data_s2;
  logic              phase;
  logic [3:0]        red;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] line_base;

  logic pclk_rise, vsync_rise, vsync_fall, href_fall;

  // Two-flop synchronizer for the whole camera bus, plus a third flop for
  // edge detection; all bits share the same delay so data stays aligned
  // with the pclk edge that qualifies it.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pclk_s1  <= 1'b0;
      pclk_s2  <= 1'b0;
      pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      vsync_s3 <= 1'b0;
      href_s1  <= 1'b0;
      href_s2  <= 1'b0;
      href_s3  <= 1'b0;
      data_s1  <= 8'h00;
      data_s2  <= 8'h00;
    end else begin
      pclk_s1  <= cam_pclk;
      pclk_s2  <= pclk_s1;
      pclk_s3  <= pclk_s2;
      vsync_s1 <= cam_vsync;
      vsync_s2 <= vsync_s1;
      vsync_s3 <= vsync_s2;
      href_s1  <= cam_href;
      href_s2  <= href_s1;
      href_s3  <= href_s2;
      data_s1  <= cam_data;
      data_s2  <= data_s1;
    end
  end

  assign pclk_rise  = pclk_s2 & ~pclk_s3;
  assign vsync_rise = vsync_s2 & ~vsync_s3;
  assign vsync_fall = ~vsync_s2 & vsync_s3;
  assign href_fall  = ~href_s2 & href_s3;

  // Frame/line sequencing, byte packing and registered frame-buffer writes.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      fb.wraddress <= '0;
      fb.wrdata    <= 12'h000;
      fb.wren      <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= 8'h00;
      busy         <= 1'b0;
      phase        <= 1'b0;
      red          <= 4'h0;
      col          <= '0;
      row          <= '0;
      line_base    <= '0;
    end else begin
      fb.wren    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (vsync_s2) state <= VBLANK;
        end
        VBLANK: begin
          busy <= 1'b0;
          if (vsync_fall && capture_en) begin
            state     <= ACTIVE;
            busy      <= 1'b1;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            phase     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (pclk_rise && href_s2) begin
            if (!phase) begin
              red   <= data_s2[3:0];
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col < COL_MAX) begin
                col <= col + COL_W'(1);
                // Only in-frame pixels touch the outputs, so the address
                // can never leave the buffer and idle outputs hold.
                if (row < ROW_MAX) begin
                  fb.wren      <= 1'b1;
                  fb.wrdata    <= {red, data_s2};
                  fb.wraddress <= line_base + ADDR_W'(col);
                end
              end
            end
          end else if (href_fall) begin
            col   <= '0;
            phase <= 1'b0;
            // Empty lines (and lines past the bottom) do not advance.
            if (col != '0 && row < ROW_MAX) begin
              row       <= row + ROW_W'(1);
              line_base <= line_base + LINE_STEP;
            end
          end
          if (vsync_rise) begin
            state       <= VBLANK;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a reduced 8x4 frame buffer so whole
// frames fit in a short run; boundary behaviour scales with the parameters.
module tb_camera_capture;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cam_pclk = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       capture_en = 1'b1;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  logic [AW-1:0] waddr_q[$];
  logic [11:0]   wdata_q[$];
  int            fd_cnt = 0;

  camera_capture_if #(.ADDR_W(AW)) fb_if ();

  camera_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_n),
    .cam_pclk      (cam_pclk),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .capture_en    (capture_en),
    .fb            (fb_if),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Record every write and every frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (fb_if.wren) begin
      waddr_q.push_back(fb_if.wraddress);
      wdata_q.push_back(fb_if.wrdata);
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One camera byte: data/href set while pclk is low, then a pclk high phase.
  task automatic send_byte(input logic [7:0] b, input logic h);
    cam_data = b;
    cam_href = h;
    cam_pclk = 1'b0;
    clks(2);
    cam_pclk = 1'b1;
    clks(2);
    cam_pclk = 1'b0;
  endtask

  task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1,
                           input logic odd_tail);
    for (int i = 0; i < npix; i++) begin
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
    end
    if (odd_tail) send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
  endtask

  task automatic vblank();
    cam_vsync = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
  endtask

  task automatic active_start();
    cam_vsync = 1'b0;
    for (int i = 0; i < 2; i++) send_byte(8'h00, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " wraddress"}, 32'(fb_if.wraddress), 32'h0);
    chk({tag, " wrdata"}, 32'(fb_if.wrdata), 32'h0);
    chk({tag, " wren"}, 32'(fb_if.wren), 32'h0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, " frame_count"}, 32'(frame_count), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int base;
    int fd0;
    int bad;

    // Reset held with vsync low and href active on the bus.
    reset_n = 1'b0;
    cam_vsync = 1'b0;
    send_byte(8'h0A, 1'b1);
    chk_outputs_zero("reset");
    reset_n = 1'b1;

    // Mid-frame traffic after reset must be ignored until a full vsync cycle.
    base = waddr_q.size();
    send_line(H, 8'h0A, 8'hBC, 1'b0);
    send_line(H, 8'h0A, 8'hBC, 1'b0);
    chk("no write before vsync", 32'(waddr_q.size() - base), 32'd0);
    chk("busy in idle", 32'(busy), 32'd0);

    // Full frame of 0x0A,0xBC pairs.
    vblank();
    base = waddr_q.size();
    fd0 = fd_cnt;
    active_start();
    for (int l = 0; l < V; l++) begin
      send_line(H, 8'h0A, 8'hBC, 1'b0);
      if (l == 1) chk("busy mid frame", 32'(busy), 32'd1);
    end
    vblank();
    chk("full frame writes", 32'(waddr_q.size() - base), 32'(H * V));
    bad = 0;
    for (int i = 0; i < H * V && base + i < waddr_q.size(); i++)
      if (waddr_q[base + i] !== AW'(i) || wdata_q[base + i] !== 12'hABC) bad++;
    chk("full frame addr/data order", 32'(bad), 32'd0);
    chk("full frame done pulses", 32'(fd_cnt - fd0), 32'd1);
    chk("frame_count after frame 1", 32'(frame_count), 32'd1);
    chk("busy after frame", 32'(busy), 32'd0);

    // Long line, empty href pulse, short line with odd tail byte, two normal lines.
    base = waddr_q.size();
    active_start();
    send_line(H + 2, 8'h01, 8'h23, 1'b0);
    cam_href = 1'b1;
    clks(4);
    cam_href = 1'b0;
    clks(4);
    send_line(3, 8'h04, 8'h56, 1'b1);
    send_line(H, 8'h07, 8'h89, 1'b0);
    send_line(H, 8'h07, 8'h89, 1'b0);
    vblank();
    chk("long/short frame writes", 32'(waddr_q.size() - base), 32'd27);
    if (waddr_q.size() >= base + 27) begin
      chk("long line last addr", 32'(waddr_q[base + 7]), 32'd7);
      chk("long line data", 32'(wdata_q[base + 7]), 32'h123);
      chk("short line first addr", 32'(waddr_q[base + 8]), 32'd8);
      chk("short line last addr", 32'(waddr_q[base + 10]), 32'd10);
      chk("third line start addr", 32'(waddr_q[base + 11]), 32'd16);
      chk("data after odd tail", 32'(wdata_q[base + 11]), 32'h789);
      chk("long/short last addr", 32'(waddr_q[base + 26]), 32'd31);
    end
    chk("frame_count after frame 2", 32'(frame_count), 32'd2);

    // Skipped frame (capture_en low at vsync fall), then an accepted frame.
    capture_en = 1'b0;
    base = waddr_q.size();
    fd0 = fd_cnt;
    active_start();
    capture_en = 1'b1;
    send_line(H, 8'h0D, 8'hEF, 1'b0);
    send_line(H, 8'h0D, 8'hEF, 1'b0);
    vblank();
    chk("skipped frame writes", 32'(waddr_q.size() - base), 32'd0);
    chk("skipped frame done", 32'(fd_cnt - fd0), 32'd0);
    chk("frame_count after skip", 32'(frame_count), 32'd2);
    active_start();
    send_line(H, 8'h0D, 8'hEF, 1'b0);
    send_line(H, 8'h0D, 8'hEF, 1'b0);
    vblank();
    chk("accepted frame writes", 32'(waddr_q.size() - base), 32'd16);
    if (waddr_q.size() >= base + 16) begin
      chk("accepted first addr", 32'(waddr_q[base]), 32'd0);
      chk("accepted last addr", 32'(waddr_q[base + 15]), 32'd15);
      chk("accepted data", 32'(wdata_q[base + 15]), 32'hDEF);
    end
    chk("frame_count after frame 3", 32'(frame_count), 32'd3);

    // Too many lines: rows past the bottom are dropped.
    base = waddr_q.size();
    active_start();
    for (int l = 0; l < V + 2; l++) send_line(H, 8'h05, 8'h5A, 1'b0);
    vblank();
    chk("extra lines writes", 32'(waddr_q.size() - base), 32'(H * V));
    bad = 0;
    for (int i = base; i < waddr_q.size(); i++)
      if (waddr_q[i] > AW'(H * V - 1)) bad++;
    chk("extra lines addr bound", 32'(bad), 32'd0);
    if (waddr_q.size() > 0)
      chk("extra lines last addr", 32'(waddr_q[waddr_q.size() - 1]), 32'(H * V - 1));
    chk("frame_count after frame 4", 32'(frame_count), 32'd4);

    // Reset mid-line on row 2; capture restarts only on the next frame.
    base = waddr_q.size();
    active_start();
    send_line(H, 8'h06, 8'h66, 1'b0);
    send_line(H, 8'h06, 8'h66, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h06, 1'b1);
      send_byte(8'h66, 1'b1);
    end
    clks(4);
    chk("pre-reset writes", 32'(waddr_q.size() - base), 32'd19);
    reset_n = 1'b0;
    clks(1);
    chk_outputs_zero("mid reset");
    reset_n = 1'b1;
    base = waddr_q.size();
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h06, 1'b1);
      send_byte(8'h66, 1'b1);
    end
    send_byte(8'h00, 1'b0);
    send_line(H, 8'h06, 8'h66, 1'b0);
    chk("post-reset idle writes", 32'(waddr_q.size() - base), 32'd0);
    vblank();
    chk("post-reset no frame_done", 32'(fd_cnt - fd0), 32'd0);
    active_start();
    send_line(H, 8'h03, 8'h21, 1'b0);
    vblank();
    chk("resumed writes", 32'(waddr_q.size() - base), 32'(H));
    if (waddr_q.size() > base) begin
      chk("resumed first addr", 32'(waddr_q[base]), 32'd0);
      chk("resumed data", 32'(wdata_q[base]), 32'h321);
    end
    chk("frame_count after resume", 32'(frame_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/camera_capture.md
Name: camera_capture

Overview:
- Write-side counterpart of the camera-to-VGA reader.
- Samples an OV7670-style 8-bit parallel camera bus in RGB444 mode and packs each two-byte pair into one 12-bit pixel.
- Writes pixels into the shared 320x240 frame buffer (17-bit address, 12-bit data) that the VGA reader scans out.
- Runs entirely in the system clock domain; camera signals are treated as asynchronous inputs.

Parameters:
- H_PIXELS, 320, pixels per line written to the buffer.
- V_LINES, 240, lines per frame written to the buffer.
- ADDR_W, 17, frame-buffer address width (H_PIXELS*V_LINES must be ≤ 2^ADDR_W).

Ports:
- clk_clk  in  1  system clock; all logic synchronous to its rising edge.
- reset_reset_n  in  1  synchronous active-low reset.
- cam_pclk  in  1  camera pixel clock, asynchronous; sampled as data.
- cam_vsync  in  1  camera frame sync, high during vertical blank.
- cam_href  in  1  camera line valid, high during active bytes.
- cam_data  in  8  camera byte bus.
- capture_en  in  1  frame-accept enable, sampled only at frame start.
- wraddress  out  ADDR_W  frame-buffer write address.
- wrdata  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
- wren  out  1  write strobe, one clk_clk cycle per pixel.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_count  out  8  count of captured frames, wraps 255->0.
- busy  out  1  high while in the ACTIVE state.

Behaviour:
- Reset (reset_reset_n=0 at a clk edge) forces wraddress=0, wrdata=0, wren=0, frame_done=0, frame_count=0, busy=0, state=IDLE, and clears all synchronizers and counters.
- Reset asserted mid-frame abandons the frame; no further writes until the next full vsync high->low sequence.
- Synchronizer: cam_pclk, cam_vsync, cam_href and cam_data all pass through the same 2-flop chain. A third pclk flop detects edges.
  - pclk_rise = s2 & ~s3.
  - Data, href and vsync are taken from stage 2 on pclk_rise.
  - Requirement: f(clk_clk) ≥ 4 × f(cam_pclk).
- Events are evaluated on the synchronized signals:
  - vsync_rise / vsync_fall: edges of synced vsync.
  - href_fall: edge of synced href.
- States:
  - IDLE: wait for synced vsync=1 -> VBLANK. Prevents capturing a partial frame after reset.
  - VBLANK: on vsync_fall with capture_en=1 -> ACTIVE. Entry clears col=0, line_base=0, row=0, phase=0. On vsync_fall with capture_en=0, stay in VBLANK; the frame is skipped.
  - ACTIVE: busy=1; on vsync_rise -> VBLANK, frame_done=1 for one cycle, frame_count+1.
- Byte packing in ACTIVE, on pclk_rise with href=1:
  - phase 0: latch R=data[3:0]; phase<=1.
  - phase 1: set wrdata={R, data[7:0]} and wraddress=line_base+col. Assert wren for exactly one cycle only if col<H_PIXELS and row<V_LINES; col+1 saturates at H_PIXELS; phase<=0.
- Write latency: wren/wrdata/wraddress are registered and valid in the cycle after the pclk_rise detect of the second byte. Total latency from the cam_pclk edge is 4 clk_clk cycles.
- Line end (href_fall in ACTIVE):
  - If col>0: row+1 (saturating at V_LINES) and line_base += H_PIXELS.
  - Always: col=0, phase=0. An odd trailing byte is discarded.
- Boundaries:
  - Long lines: bytes beyond H_PIXELS pixels are dropped with no write.
  - Lines beyond V_LINES: dropped.
  - Short lines: the remainder of the buffer line is untouched; the next line still starts at line_base.
  - Empty href pulse: no row advance.
  - vsync_rise simultaneous with a phase-1 byte: the pixel write completes, then frame_done is issued.
  - Address never exceeds H_PIXELS*V_LINES−1.
- wren=0 in IDLE and VBLANK; outputs hold their last values when wren=0.

Test Plan:
- Reset then one 320x240 frame of byte pairs (0x0A, 0xBC) -> 76800 wren pulses, wrdata=0xABC, addresses 0..76799 in order, one frame_done, frame_count=1.
- Reset released while vsync=0 and href active -> no wren until vsync goes 1 then 0; first write at address 0.
- Line of 330 pixels, then a line of 100 pixels -> line 0 writes addresses 0..319 only; line 1 writes addresses 320..419; the third line starts at 640.
- capture_en=0 at vsync_fall of frame 2, 1 at frame 3 -> frame 2 produces no writes and no frame_done; frame_count steps 1->2 after frame 3.
- 245 lines in a frame -> no wren for rows 240..244; last address 76799.
- reset_reset_n pulsed low mid-line at row 100 -> all outputs 0 next cycle; capture resumes only at the following frame with address 0.
